// File: rtl/mem_arb_pkg.sv
// Shared types for the memory write arbiter: controller states and requester ids.
// Grant policy is selected by MEM_WRITE_ARB_ROUND_ROBIN_EN (see mem_arb_grant).
package mem_arb_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } arb_state_e;

  typedef enum logic {
    HOST   = 1'b0,
    ENGINE = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Two-way combinational grant between host and engine write requesters.
// Define MEM_WRITE_ARB_ROUND_ROBIN_EN for round-robin; otherwise the host always wins.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic allow,
  input  logic host_valid,
  input  logic eng_valid,
  output logic host_ready,
  output logic eng_ready
);

`ifdef MEM_WRITE_ARB_ROUND_ROBIN_EN
  req_id_e last_grant_q;
  req_id_e last_grant_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    host_ready   = 1'b0;
    eng_ready    = 1'b0;
    last_grant_d = last_grant_q;
    if (allow) begin
      if (host_valid && eng_valid) begin
        host_ready = (last_grant_q == ENGINE);
        eng_ready  = (last_grant_q == HOST);
      end else begin
        host_ready = host_valid;
        eng_ready  = eng_valid;
      end
    end
    // A ready is only raised alongside its valid, so ready implies acceptance.
    if (host_ready) begin
      last_grant_d = HOST;
    end else if (eng_ready) begin
      last_grant_d = ENGINE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= ENGINE;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  always_comb begin
    host_ready = 1'b0;
    eng_ready  = 1'b0;
    if (allow) begin
      host_ready = host_valid;
      eng_ready  = eng_valid && !host_valid;
    end
  end
`endif

endmodule

// File: rtl/mem_write_arbiter.sv
// Arbitrates host/engine writes onto one registered memory write port and runs clear sweeps.
// Grant policy: MEM_WRITE_ARB_ROUND_ROBIN_EN defined -> round-robin, else host priority.
module mem_write_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    DEPTH         = 16,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]    host_data,
  input  logic                     eng_valid,
  output logic                     eng_ready,
  input  logic [$clog2(DEPTH)-1:0] eng_addr,
  input  logic [DATA_WIDTH-1:0]    eng_data,
  output logic                     wea,
  output logic [$clog2(DEPTH)-1:0] addra,
  output logic [DATA_WIDTH-1:0]    dia,
  output logic                     busy,
  output logic                     clear_done_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  arb_state_e            state_q, state_d;
  logic [AW-1:0]         sweep_addr_q, sweep_addr_d;
  logic                  wea_q, wea_d;
  logic [AW-1:0]         addra_q, addra_d;
  logic [DATA_WIDTH-1:0] dia_q, dia_d;
  logic                  clear_done_q, clear_done_d;

  logic allow;
  logic host_acc;
  logic eng_acc;

  // Readies drop during reset, throughout a sweep, and whenever a clear is being requested.
  assign allow = !reset && (state_q == IDLE) && !clear_req;

  mem_arb_grant u_grant (
    .clk        (clk),
    .reset      (reset),
    .allow      (allow),
    .host_valid (host_valid),
    .eng_valid  (eng_valid),
    .host_ready (host_ready),
    .eng_ready  (eng_ready)
  );

  assign host_acc = host_valid && host_ready;
  assign eng_acc  = eng_valid && eng_ready;

  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    wea_d        = 1'b0;
    addra_d      = addra_q;
    dia_d        = dia_q;
    clear_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d      = CLEARING;
          sweep_addr_d = '0;
        end else if (host_acc) begin
          wea_d   = 1'b1;
          addra_d = host_addr;
          dia_d   = host_data;
        end else if (eng_acc) begin
          wea_d   = 1'b1;
          addra_d = eng_addr;
          dia_d   = eng_data;
        end
      end
      CLEARING: begin
        wea_d        = 1'b1;
        addra_d      = sweep_addr_q;
        dia_d        = DEFAULT_VALUE;
        sweep_addr_d = sweep_addr_q + 1'b1;
        if (sweep_addr_q == LAST_ADDR) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sweep_addr_q <= '0;
      wea_q        <= 1'b0;
      addra_q      <= '0;
      dia_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      wea_q        <= wea_d;
      addra_q      <= addra_d;
      dia_q        <= dia_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign wea              = wea_q;
  assign addra            = addra_q;
  assign dia              = dia_q;
  assign busy             = (state_q == CLEARING);
  assign clear_done_pulse = clear_done_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed self-checking bench for mem_write_arbiter (DEPTH 16, DEFAULT_VALUE 0xA5).
module tb_mem_write_arbiter;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam logic [DW-1:0] DEF = 8'hA5;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_req;
  logic          host_valid, host_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          eng_valid, eng_ready;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_data;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dia;
  logic          busy;
  logic          clear_done_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_write_arbiter #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .DEFAULT_VALUE (DEF)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .clear_req        (clear_req),
    .host_valid       (host_valid),
    .host_ready       (host_ready),
    .host_addr        (host_addr),
    .host_data        (host_data),
    .eng_valid        (eng_valid),
    .eng_ready        (eng_ready),
    .eng_addr         (eng_addr),
    .eng_data         (eng_data),
    .wea              (wea),
    .addra            (addra),
    .dia              (dia),
    .busy             (busy),
    .clear_done_pulse (clear_done_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_host;
    int         writes;
    int         dones;
    int         busy_cycles;
    int         next_addr;

`ifdef MEM_WRITE_ARB_ROUND_ROBIN_EN
    exp_host = 4'b0101;
`else
    exp_host = 4'b1111;
`endif

    reset = 1'b1; clear_req = 1'b0;
    host_valid = 1'b0; host_addr = '0; host_data = '0;
    eng_valid = 1'b0; eng_addr = '0; eng_data = '0;
    step();
    host_valid = 1'b1; eng_valid = 1'b1; clear_req = 1'b1;
    #1;
    check("reset_host_ready", 32'(host_ready), 32'd0);
    check("reset_eng_ready", 32'(eng_ready), 32'd0);
    step();
    check("reset_wea", 32'(wea), 32'd0);
    check("reset_addra", 32'(addra), 32'd0);
    check("reset_dia", 32'(dia), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(clear_done_pulse), 32'd0);
    reset = 1'b0; clear_req = 1'b0; host_valid = 1'b0; eng_valid = 1'b0;
    step();

    // Single host write.
    host_valid = 1'b1; host_addr = 4'd3; host_data = 8'h5A;
    #1;
    check("host_only_hready", 32'(host_ready), 32'd1);
    check("host_only_eready", 32'(eng_ready), 32'd0);
    step();
    host_valid = 1'b0;
    check("host_wr_wea", 32'(wea), 32'd1);
    check("host_wr_addra", 32'(addra), 32'd3);
    check("host_wr_dia", 32'(dia), 32'h5A);
    step();
    check("idle_wea", 32'(wea), 32'd0);
    check("hold_addra", 32'(addra), 32'd3);
    check("hold_dia", 32'(dia), 32'h5A);

    // Single engine write.
    eng_valid = 1'b1; eng_addr = 4'd9; eng_data = 8'hC3;
    #1;
    check("eng_only_hready", 32'(host_ready), 32'd0);
    check("eng_only_eready", 32'(eng_ready), 32'd1);
    step();
    eng_valid = 1'b0;
    check("eng_wr_wea", 32'(wea), 32'd1);
    check("eng_wr_addra", 32'(addra), 32'd9);
    check("eng_wr_dia", 32'(dia), 32'hC3);

    // Contention for four cycles; last acceptance was the engine.
    host_valid = 1'b1; host_addr = 4'd1; host_data = 8'h11;
    eng_valid  = 1'b1; eng_addr  = 4'd2; eng_data  = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont%0d_hready", i), 32'(host_ready), 32'(exp_host[i]));
      check($sformatf("cont%0d_eready", i), 32'(eng_ready), 32'(!exp_host[i]));
      step();
      check($sformatf("cont%0d_wea", i), 32'(wea), 32'd1);
      check($sformatf("cont%0d_addra", i), 32'(addra), exp_host[i] ? 32'd1 : 32'd2);
      check($sformatf("cont%0d_dia", i), 32'(dia), exp_host[i] ? 32'h11 : 32'h22);
    end
    eng_valid = 1'b0;
    host_valid = 1'b0;
    step();

    // Clear together with a host request: clear wins, host waits for the sweep.
    clear_req = 1'b1; host_valid = 1'b1; host_addr = 4'd4; host_data = 8'h44;
    #1;
    check("clr_host_ready", 32'(host_ready), 32'd0);
    step();
    clear_req = 1'b0;
    busy_cycles = 0;
    for (int j = 0; j < DEPTH; j++) begin
      if (busy) busy_cycles++;
      check($sformatf("sweep%0d_hready", j), 32'(host_ready), 32'd0);
      step();
      check($sformatf("sweep%0d_wea", j), 32'(wea), 32'd1);
      check($sformatf("sweep%0d_addra", j), 32'(addra), 32'(j));
      check($sformatf("sweep%0d_dia", j), 32'(dia), 32'(DEF));
      check($sformatf("sweep%0d_done", j), 32'(clear_done_pulse), 32'(j == DEPTH - 1));
    end
    check("sweep_busy_cycles", 32'(busy_cycles), 32'(DEPTH));
    check("post_sweep_busy", 32'(busy), 32'd0);
    check("post_sweep_hready", 32'(host_ready), 32'd1);
    step();
    host_valid = 1'b0;
    check("post_sweep_wea", 32'(wea), 32'd1);
    check("post_sweep_addra", 32'(addra), 32'd4);
    check("post_sweep_dia", 32'(dia), 32'h44);
    check("post_sweep_done", 32'(clear_done_pulse), 32'd0);

    // clear_req re-asserted mid-sweep is ignored.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    writes = 0; dones = 0; next_addr = 0;
    for (int k = 0; k < 24; k++) begin
      clear_req = (k == 5 || k == 6);
      step();
      if (wea) begin
        check($sformatf("reclr_order%0d", writes), 32'(addra), 32'(next_addr));
        writes++;
        next_addr++;
      end
      if (clear_done_pulse) dones++;
    end
    clear_req = 1'b0;
    check("reclr_writes", 32'(writes), 32'(DEPTH));
    check("reclr_dones", 32'(dones), 32'd1);
    check("reclr_busy_end", 32'(busy), 32'd0);

    // Reset while sweep_addr = 7 aborts the sweep.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int j = 0; j < 7; j++) step();
    check("abort_pre_addra", 32'(addra), 32'd6);
    reset = 1'b1; host_valid = 1'b1;
    #1;
    check("abort_rst_hready", 32'(host_ready), 32'd0);
    step();
    host_valid = 1'b0;
    check("abort_wea", 32'(wea), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(clear_done_pulse), 32'd0);
    reset = 1'b0;
    writes = 0; dones = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (wea) writes++;
      if (clear_done_pulse) dones++;
      if (busy) dones++;
    end
    check("abort_no_writes", 32'(writes), 32'd0);
    check("abort_no_done_or_busy", 32'(dones), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_write_arbiter.md
MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of a memory word.
REQ-002 SHALL have parameter DEPTH, default 16, number of words in the arbitrated memory; power of two, >= 2.
REQ-003 SHALL have parameter DEFAULT_VALUE, default '0, word written at every address during a clear sweep.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port clear_req  input  1  request to sweep the whole memory to DEFAULT_VALUE.
REQ-007 SHALL have port host_valid / host_ready  input / output  1 / 1  host write handshake.
REQ-008 SHALL have port host_addr / host_data  input / input  $clog2(DEPTH) / DATA_WIDTH  host write address and data.
REQ-009 SHALL have port eng_valid / eng_ready  input / output  1 / 1  engine write handshake.
REQ-010 SHALL have port eng_addr / eng_data  input / input  $clog2(DEPTH) / DATA_WIDTH  engine write address and data.
REQ-011 SHALL have port wea / addra / dia  output / output / output  1 / $clog2(DEPTH) / DATA_WIDTH  registered write port to the memory.
REQ-012 SHALL have port busy  output  1  high while a clear sweep is in progress.
REQ-013 SHALL have port clear_done_pulse  output  1  one-cycle pulse when the sweep completes.

Function
REQ-014 SHALL implement states IDLE and CLEARING plus registers sweep_addr and last_grant.
REQ-015 SHALL treat a requester as accepted in a cycle where valid and ready are both high.
REQ-016 SHALL drive host_ready and eng_ready combinationally; both SHALL be low in CLEARING, and low in IDLE when clear_req is high.
REQ-017 SHALL, in IDLE with clear_req high, move to CLEARING next cycle with sweep_addr = 0; clear has priority over both requesters.
REQ-018 SHALL, in IDLE with no clear_req and one requester valid, raise only that requester's ready.
REQ-019 SHALL, in IDLE with no clear_req and both requesters valid, raise exactly one ready, chosen per REQ-031/REQ-032.
REQ-020 SHALL register the accepted address/data onto addra/dia with wea = 1 in the cycle after acceptance (latency 1); wea = 0 in cycles after no acceptance and no sweep step.
REQ-021 SHALL, in each CLEARING cycle, issue sweep_addr with DEFAULT_VALUE, appearing on wea/addra/dia the following cycle, then increment sweep_addr.
REQ-022 SHALL, in the CLEARING cycle where sweep_addr = DEPTH-1, return to IDLE next cycle; clear_done_pulse SHALL be high in the same cycle as the write of DEPTH-1 on the outputs.
REQ-023 SHALL make a sweep exactly DEPTH writes to addresses 0..DEPTH-1 in ascending order, with no wrap or repeat.
REQ-024 SHALL ignore clear_req while in CLEARING; a new sweep needs clear_req high in IDLE.
REQ-025 SHALL drive busy high exactly in CLEARING cycles.
REQ-026 SHALL hold addra/dia at their last values when wea = 0.

Reset
REQ-027 SHALL, on reset, set state = IDLE, sweep_addr = 0, last_grant = engine (so the host wins the first contention), wea = 0, addra = 0, dia = 0, clear_done_pulse = 0.
REQ-028 SHALL, on reset mid-sweep, abort the sweep with no further sweep writes and no clear_done_pulse.
REQ-029 SHALL keep host_ready = eng_ready = 0 during reset cycles.
REQ-030 SHALL give reset priority over clear_req and over the requesters in the same cycle.

Configuration
REQ-031 SHALL, with MEM_WRITE_ARB_ROUND_ROBIN_EN defined, grant the requester not named in last_grant on contention, and update last_grant on every acceptance.
REQ-032 SHALL, without MEM_WRITE_ARB_ROUND_ROBIN_EN, always grant the host on contention; last_grant is then not implemented.

Structure
REQ-033 SHALL place the state enum and the requester-id type (HOST, ENGINE) in the shared package mem_arb_pkg.
REQ-034 SHALL contain one sub-module, mem_arb_grant, holding the combinational two-way grant logic and last_grant.

Verification
REQ-035 SHALL cover: host write addr 3, data 0x5A in IDLE -> wea = 1, addra = 3, dia = 0x5A one cycle later.
REQ-036 SHALL cover: clear_req for 1 cycle with DEPTH = 16 -> busy high for 16 cycles, addresses 0..15 written with DEFAULT_VALUE, clear_done_pulse with addra = 15.
REQ-037 SHALL cover: clear_req and host_valid in the same IDLE cycle -> host_ready = 0, sweep starts, host accepted on the first IDLE cycle after the sweep.
REQ-038 SHALL cover: both valid for 4 cycles -> with the macro, grants alternate H,E,H,E; without it, H,H,H,H.
REQ-039 SHALL cover: reset asserted at sweep_addr = 7 -> no write of address 8, no clear_done_pulse, state IDLE, busy = 0.
REQ-040 SHALL cover: clear_req re-asserted mid-sweep -> ignored; exactly 16 writes and one clear_done_pulse.
